// File: rtl/cla_acc_pkg.sv
// cla_acc_pkg
// Shared definitions for the 25-bit streaming accumulator:
//   - acc_state_t   : accumulator FSM state (IDLE, ACCUM, HOLD), 2-bit encoding
//   - CLA_ACC_WIDTH : operand/sum width, matches the CLA_25bit adder
//   - CLA_ACC_CNT_W : default beat-counter width
//   - CLA_ACC_CNT_SAT : saturation value of the default beat counter
package cla_acc_pkg;

  localparam int CLA_ACC_WIDTH = 25;
  localparam int CLA_ACC_CNT_W = 8;
  localparam logic [CLA_ACC_CNT_W-1:0] CLA_ACC_CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/cla25_stream_acc_cla.sv
// CLA_25bit
// Block carry-lookahead adder, 4-bit groups. Group generate/propagate are
// formed from the operands only, so the carry into each group comes from
// the lookahead chain rather than rippling through the previous group.
// Ports:
//   A, B    [width:1]  operands
//   cin                carry in
//   S       [width:1]  sum
//   cout               carry out of the top bit
//   p_1_25             propagate across the whole word
//   g_1_25             generate across the whole word (carry out with cin=0)
module CLA_25bit #(
  parameter int width = 25
) (
  input  logic [width:1] A,
  input  logic [width:1] B,
  input  logic           cin,
  output logic [width:1] S,
  output logic           cout,
  output logic           p_1_25,
  output logic           g_1_25
);

  localparam int NBLK = (width + 3) / 4;
  localparam int PW   = NBLK * 4;

  // Operands padded to a whole number of 4-bit groups; pad bits are 0 so
  // they neither generate nor propagate.
  logic [PW:1] pe;
  logic [PW:1] ge;
  // c[i] is the carry out of bit i; c[0] is cin.
  logic [PW:0] c;
  logic        blk_g;
  logic        blk_p;
  logic        blk_cin;
  logic        word_g;

  always_comb begin
    pe = '0;
    ge = '0;
    pe[width:1] = A ^ B;
    ge[width:1] = A & B;
    c       = '0;
    c[0]    = cin;
    blk_cin = cin;
    blk_g   = 1'b0;
    blk_p   = 1'b1;
    for (int b = 0; b < NBLK; b++) begin
      // Group G/P from operand bits only.
      blk_g = 1'b0;
      blk_p = 1'b1;
      for (int k = 0; k < 4; k++) begin
        blk_g = ge[b*4+k+1] | (pe[b*4+k+1] & blk_g);
        blk_p = blk_p & pe[b*4+k+1];
      end
      // Carries inside the group start from the looked-ahead group carry-in.
      c[b*4] = blk_cin;
      for (int k = 0; k < 4; k++) begin
        c[b*4+k+1] = ge[b*4+k+1] | (pe[b*4+k+1] & c[b*4+k]);
      end
      blk_cin = blk_g | (blk_p & blk_cin);
    end
  end

  always_comb begin
    word_g = 1'b0;
    for (int i = 1; i <= width; i++) begin
      word_g = ge[i] | (pe[i] & word_g);
    end
  end

  assign S      = pe[width:1] ^ c[width-1:0];
  assign cout   = c[width];
  assign p_1_25 = &pe[width:1];
  assign g_1_25 = word_g;

endmodule

// File: rtl/cla25_stream_acc.sv
// cla25_stream_acc
// Streaming accumulator in front of CLA_25bit. Each accepted input word is
// added to the running sum; the final beat of a burst moves the block to
// HOLD, where the total is presented until the consumer takes it.
// Optional macro CLA25_ACC_SUB_EN adds port in_sub: a beat with in_sub=1 is
// subtracted instead of added, and a borrow sets the sticky overflow flag.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_data [WIDTH:1]    operand
//   in_last              final beat of the burst
//   in_sub               (CLA25_ACC_SUB_EN only) subtract this beat
//   out_valid/out_ready  result handshake
//   out_sum [WIDTH:1]    burst total modulo 2^WIDTH
//   out_ovf              sticky carry-out/borrow seen during the burst
//   out_count [CNT_W]    beats accepted in the burst, saturating
//   dbg_state            current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge;
// out_valid is never withdrawn and out_* are stable until the transfer.
module cla25_stream_acc
  import cla_acc_pkg::*;
#(
  parameter int WIDTH = CLA_ACC_WIDTH,
  parameter int CNT_W = CLA_ACC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   in_data,
  input  logic             in_last,
`ifdef CLA25_ACC_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_t       state;
  logic [WIDTH:1]   acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH:1]   adder_b;
  logic             adder_cin;
  logic [WIDTH:1]   adder_s;
  logic             adder_cout;
  logic             adder_p_unused;
  logic             adder_g_unused;
  logic             ovf_hit;
  logic             beat;

`ifdef CLA25_ACC_SUB_EN
  // Subtraction as acc + ~in_data + 1; a missing carry-out is a borrow.
  always_comb begin
    adder_b   = in_sub ? ~in_data : in_data;
    adder_cin = in_sub;
    ovf_hit   = in_sub ? ~adder_cout : adder_cout;
  end
`else
  always_comb begin
    adder_b   = in_data;
    adder_cin = 1'b0;
    ovf_hit   = adder_cout;
  end
`endif

  CLA_25bit #(
    .width (WIDTH)
  ) u_cla (
    .A      (acc),
    .B      (adder_b),
    .cin    (adder_cin),
    .S      (adder_s),
    .cout   (adder_cout),
    .p_1_25 (adder_p_unused),
    .g_1_25 (adder_g_unused)
  );

  assign beat = in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc <= adder_s;
            ovf <= ovf | ovf_hit;
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
            if (in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // out_valid is 1 throughout HOLD, so out_ready alone completes it.
          if (out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          ovf         <= 1'b0;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_cla25_stream_acc.sv
// Directed bench for cla25_stream_acc. Two instances share one input
// stream: dut (CNT_W=8) and dut_sat (CNT_W=2, for counter saturation).
module tb_cla25_stream_acc;

  localparam int W = 25;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W:1]    in_data;
  logic          in_last;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W:1]    out_sum;
  logic          out_ovf;
  logic [7:0]    out_count;
  logic [1:0]    dbg_state;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [W:1]    s_out_sum;
  logic          s_out_ovf;
  logic [1:0]    s_out_count;
  logic [1:0]    s_dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  cla25_stream_acc #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef CLA25_ACC_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  cla25_stream_acc #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef CLA25_ACC_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_sum   (s_out_sum),
    .out_ovf   (s_out_ovf),
    .out_count (s_out_count),
    .dbg_state (s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: called and return at a falling edge.
  task automatic send_beat(input logic [W:1] d, input logic last, input logic sub);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_sub   = sub;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [W:1] sum,
                               input logic ovf, input logic [7:0] cnt);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(sum));
    check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  logic [W:1] held_sum;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    held_sum  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 1: three-beat burst, consumer always ready.
    send_beat(25'h0000005, 1'b0, 1'b0);
    check("t1_accum_state", 32'(dbg_state), 32'd1);
    check("t1_no_early_valid", 32'(out_valid), 32'd0);
    send_beat(25'h0000007, 1'b0, 1'b0);
    send_beat(25'h0000010, 1'b1, 1'b0);
    expect_result("t1", 25'h000001C, 1'b0, 8'd3);
    check("t1_in_ready_hold", 32'(in_ready), 32'd0);
    take_result("t1");

    // 2: wrap-around sets the sticky flag; the next burst starts clean.
    send_beat(25'h1FFFFFF, 1'b0, 1'b0);
    send_beat(25'h0000001, 1'b1, 1'b0);
    expect_result("t2a", 25'h0000000, 1'b1, 8'd2);
    take_result("t2a");
    send_beat(25'h0000002, 1'b1, 1'b0);
    expect_result("t2b", 25'h0000002, 1'b0, 8'd1);
    take_result("t2b");

    // 3: backpressure; a waiting input beat must not be taken during HOLD.
    out_ready = 1'b0;
    send_beat(25'h0ABCDE, 1'b1, 1'b0);
    expect_result("t3", 25'h00ABCDE, 1'b0, 8'd1);
    in_valid = 1'b1;
    in_data  = 25'h0000005;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_sum",   32'(out_sum),   32'h00ABCDE);
      check("t3_hold_count", 32'(out_count), 32'd1);
      check("t3_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("t3");
    check("t3_acc_cleared", 32'(out_sum), 32'd0);
    send_beat(25'h0000001, 1'b1, 1'b0);
    expect_result("t3_after", 25'h0000001, 1'b0, 8'd1);
    take_result("t3_after");

    // 4: five beats; the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      send_beat(25'h0000001, (i == 4), 1'b0);
    end
    expect_result("t4", 25'h0000005, 1'b0, 8'd5);
    check("t4_sat_valid", 32'(s_out_valid), 32'd1);
    check("t4_sat_sum",   32'(s_out_sum),   32'h0000005);
    check("t4_sat_count", 32'(s_out_count), 32'd3);
    take_result("t4");

    // 5: reset in the middle of a burst discards the partial sum.
    send_beat(25'h0000100, 1'b0, 1'b0);
    send_beat(25'h0000100, 1'b0, 1'b0);
    check("t5_partial_sum", 32'(out_sum), 32'h0000200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_sum",   32'(out_sum),   32'd0);
    check("t5_rst_count", 32'(out_count), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    check("t5_rst_ready", 32'(in_ready),  32'd1);
    send_beat(25'h0000001, 1'b1, 1'b0);
    expect_result("t5", 25'h0000001, 1'b0, 8'd1);
    take_result("t5");

    // 6: subtraction below zero borrows.
`ifdef CLA25_ACC_SUB_EN
    send_beat(25'h0000003, 1'b0, 1'b0);
    send_beat(25'h0000005, 1'b1, 1'b1);
    expect_result("t6", 25'h1FFFFFE, 1'b1, 8'd2);
    take_result("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
